// File: rtl/vliw_issue_interlock.sv
// Multi-slot VLIW ID->EX issue stage with a per-register load scoreboard and load-use interlock.
// Optional stall_count output is enabled by defining ISSUE_STALL_COUNTER_EN.
module vliw_issue_interlock #(
  parameter int NUM_SLOTS  = 2,
  parameter int REG_ADDR_W = 3,
  parameter int PAYLOAD_W  = 64,
  parameter int LOAD_LAT   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            id_valid,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] id_rs_a,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] id_rs_b,
  input  logic [NUM_SLOTS-1:0]            id_rs_a_used,
  input  logic [NUM_SLOTS-1:0]            id_rs_b_used,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] id_rd,
  input  logic [NUM_SLOTS-1:0]            id_rd_we,
  input  logic [NUM_SLOTS-1:0]            id_is_load,
  input  logic [NUM_SLOTS*PAYLOAD_W-1:0]  id_payload,
  input  logic                            flush,
  input  logic                            ex_ready,
  output logic                            id_stall,
  output logic                            ex_valid,
  output logic [NUM_SLOTS*REG_ADDR_W-1:0] ex_rd,
  output logic [NUM_SLOTS-1:0]            ex_rd_we,
  output logic [NUM_SLOTS*PAYLOAD_W-1:0]  ex_payload,
  output logic                            ex_conflict
`ifdef ISSUE_STALL_COUNTER_EN
  ,
  output logic [15:0]                     stall_count
`endif
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W    = $clog2(LOAD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0]              r_sb_cnt [NUM_REGS];
  logic                          r_ex_valid;
  logic [NUM_SLOTS*REG_ADDR_W-1:0] r_ex_rd;
  logic [NUM_SLOTS-1:0]          r_ex_rd_we;
  logic [NUM_SLOTS*PAYLOAD_W-1:0] r_ex_payload;
  logic                          r_ex_conflict;

  logic [NUM_REGS-1:0]           w_busy;
  logic [NUM_REGS-1:0]           w_set;
  logic                          w_hazard;
  logic                          w_issue;
  logic                          w_conflict;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_busy[r] = (r_sb_cnt[r] != '0);
    end
  end

  // Sources are checked only against the scoreboard, never against same-bundle destinations.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    w_hazard = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (id_rs_a_used[s] && w_busy[id_rs_a[s*REG_ADDR_W +: REG_ADDR_W]]) w_hazard = 1'b1;
      if (id_rs_b_used[s] && w_busy[id_rs_b[s*REG_ADDR_W +: REG_ADDR_W]]) w_hazard = 1'b1;
    end
    w_hazard = w_hazard & id_valid;
  end

  assign w_issue  = id_valid & ~flush & ~w_hazard & ex_ready;
  assign id_stall = id_valid & ~flush & (w_hazard | ~ex_ready);

  always_comb begin
    w_set = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (w_issue && id_rd_we[s] && id_is_load[s] &&
            id_rd[s*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)) begin
          w_set[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = i + 1; j < NUM_SLOTS; j++) begin
        if (id_rd_we[i] && id_rd_we[j] &&
            id_rd[i*REG_ADDR_W +: REG_ADDR_W] == id_rd[j*REG_ADDR_W +: REG_ADDR_W]) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Counters freeze while EX is back-pressured; a new load set wins over the decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the scoreboard is state the interlock depends on, so every entry is reset, not left X.
      for (int r = 0; r < NUM_REGS; r++) r_sb_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_set[r])                  r_sb_cnt[r] <= LAT_INIT;
        else if (ex_ready && w_busy[r]) r_sb_cnt[r] <= r_sb_cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_rd_we    <= '0;
      r_ex_payload  <= '0;
      r_ex_conflict <= 1'b0;
    end else if (ex_ready) begin
      if (w_issue) begin
        r_ex_valid    <= 1'b1;
        r_ex_rd       <= id_rd;
        r_ex_rd_we    <= id_rd_we;
        r_ex_payload  <= id_payload;
        r_ex_conflict <= w_conflict;
      end else begin
        r_ex_valid    <= 1'b0;
        r_ex_rd       <= '0;
        r_ex_rd_we    <= '0;
        r_ex_payload  <= '0;
        r_ex_conflict <= 1'b0;
      end
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_rd       = r_ex_rd;
  assign ex_rd_we    = r_ex_rd_we;
  assign ex_payload  = r_ex_payload;
  assign ex_conflict = r_ex_conflict;

`ifdef ISSUE_STALL_COUNTER_EN
  logic [15:0] r_stall_cnt;

  // Counts only hazard stalls, not pure back-pressure stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (id_stall && w_hazard && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vliw_issue_interlock.sv
// Directed bench for vliw_issue_interlock: a vector table on a LOAD_LAT=1 instance plus
// hand-written sequences for latency 3, back-pressure and asynchronous reset.
module tb_vliw_issue_interlock;

  localparam logic [127:0] P1  = {64'h1111_0000_0000_0001, 64'h1111_0000_0000_0000};
  localparam logic [127:0] P2  = {64'h2222_0000_0000_0001, 64'h2222_0000_0000_0000};
  localparam logic [127:0] P3  = {64'h3333_0000_0000_0001, 64'h3333_0000_0000_0000};
  localparam logic [127:0] P4  = {64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000};
  localparam logic [127:0] P5  = {64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
  localparam logic [127:0] P6  = {64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000};
  localparam logic [127:0] P7  = {64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
  localparam logic [127:0] P8  = {64'h8888_0000_0000_0001, 64'h8888_0000_0000_0000};
  localparam logic [127:0] P9  = {64'h9999_0000_0000_0001, 64'h9999_0000_0000_0000};
  localparam logic [127:0] P10 = {64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000};
  localparam logic [127:0] P11 = {64'hBBBB_0000_0000_0001, 64'hBBBB_0000_0000_0000};

  logic         clk;
  logic         reset;
  logic         id_valid, flush, ex_ready;
  logic [5:0]   id_rs_a, id_rs_b, id_rd;
  logic [1:0]   id_rs_a_used, id_rs_b_used, id_rd_we, id_is_load;
  logic [127:0] id_payload;

  logic         stall1, valid1, conf1, stall3, valid3, conf3;
  logic [5:0]   rd1, rd3;
  logic [1:0]   we1, we3;
  logic [127:0] pl1, pl3;
`ifdef ISSUE_STALL_COUNTER_EN
  logic [15:0]  scnt1, scnt3;
`endif

  int checks = 0;
  int errors = 0;

  vliw_issue_interlock #(.NUM_SLOTS(2), .REG_ADDR_W(3), .PAYLOAD_W(64), .LOAD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rs_a_used(id_rs_a_used), .id_rs_b_used(id_rs_b_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_payload(id_payload),
    .flush(flush), .ex_ready(ex_ready), .id_stall(stall1), .ex_valid(valid1), .ex_rd(rd1),
    .ex_rd_we(we1), .ex_payload(pl1), .ex_conflict(conf1)
`ifdef ISSUE_STALL_COUNTER_EN
    , .stall_count(scnt1)
`endif
  );

  vliw_issue_interlock #(.NUM_SLOTS(2), .REG_ADDR_W(3), .PAYLOAD_W(64), .LOAD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rs_a_used(id_rs_a_used), .id_rs_b_used(id_rs_b_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_payload(id_payload),
    .flush(flush), .ex_ready(ex_ready), .id_stall(stall3), .ex_valid(valid3), .ex_rd(rd3),
    .ex_rd_we(we3), .ex_payload(pl3), .ex_conflict(conf3)
`ifdef ISSUE_STALL_COUNTER_EN
    , .stall_count(scnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v, fl, rdy;
    logic [5:0]   rsa, rsb;
    logic [1:0]   ua, ub;
    logic [5:0]   rd;
    logic [1:0]   we, ld;
    logic [127:0] pl;
    logic         e_stall, e_valid;
    logic [1:0]   e_we;
    logic [5:0]   e_rd;
    logic         e_conf;
    logic [127:0] e_pl;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, fl, rdy, input logic [5:0] rsa, rsb,
                        input logic [1:0] ua, ub, input logic [5:0] rd,
                        input logic [1:0] we, ld, input logic [127:0] pl);
    id_valid = v; flush = fl; ex_ready = rdy;
    id_rs_a = rsa; id_rs_b = rsb; id_rs_a_used = ua; id_rs_b_used = ub;
    id_rd = rd; id_rd_we = we; id_is_load = ld; id_payload = pl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #4 reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, fl, rdy, input logic [5:0] rsa, rsb,
                              input logic [1:0] ua, ub, input logic [5:0] rd,
                              input logic [1:0] we, ld, input logic [127:0] pl,
                              input logic es, ev, input logic [1:0] ewe,
                              input logic [5:0] erd, input logic ec, input logic [127:0] epl);
    vec_t t;
    t.v = v; t.fl = fl; t.rdy = rdy; t.rsa = rsa; t.rsb = rsb; t.ua = ua; t.ub = ub;
    t.rd = rd; t.we = we; t.ld = ld; t.pl = pl;
    t.e_stall = es; t.e_valid = ev; t.e_we = ewe; t.e_rd = erd; t.e_conf = ec; t.e_pl = epl;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, '0);

    // slot fields are {slot1, slot0}; LOAD_LAT=1 instance
    vecs[0]  = mk(0,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o00, 2'b00,2'b00, '0,  0,0,2'b00,6'o00,0,'0);
    vecs[1]  = mk(1,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o30, 2'b10,2'b10, P1,  0,1,2'b10,6'o30,0,P1);
    vecs[2]  = mk(1,0,1, 6'o03,6'o00, 2'b01,2'b00, 6'o01, 2'b01,2'b00, P2,  1,0,2'b00,6'o00,0,'0);
    vecs[3]  = mk(1,0,1, 6'o03,6'o00, 2'b01,2'b00, 6'o01, 2'b01,2'b00, P2,  0,1,2'b01,6'o01,0,P2);
    vecs[4]  = mk(1,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o03, 2'b01,2'b01, P3,  0,1,2'b01,6'o03,0,P3);
    vecs[5]  = mk(1,0,1, 6'o03,6'o40, 2'b00,2'b10, 6'o00, 2'b00,2'b00, P4,  0,1,2'b00,6'o00,0,P4);
    vecs[6]  = mk(1,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o55, 2'b11,2'b00, P5,  0,1,2'b11,6'o55,1,P5);
    vecs[7]  = mk(1,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o65, 2'b11,2'b00, P6,  0,1,2'b11,6'o65,0,P6);
    vecs[8]  = mk(1,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o55, 2'b01,2'b00, P7,  0,1,2'b01,6'o55,0,P7);
    vecs[9]  = mk(1,0,1, 6'o20,6'o00, 2'b10,2'b00, 6'o02, 2'b01,2'b01, P8,  0,1,2'b01,6'o02,0,P8);
    vecs[10] = mk(1,1,1, 6'o02,6'o00, 2'b01,2'b00, 6'o01, 2'b01,2'b00, P9,  0,0,2'b00,6'o00,0,'0);
    vecs[11] = mk(1,0,1, 6'o02,6'o00, 2'b01,2'b00, 6'o01, 2'b01,2'b00, P9,  0,1,2'b01,6'o01,0,P9);
    vecs[12] = mk(1,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o70, 2'b10,2'b10, P10, 0,1,2'b10,6'o70,0,P10);
    vecs[13] = mk(1,0,1, 6'o00,6'o70, 2'b00,2'b10, 6'o00, 2'b00,2'b00, P11, 1,0,2'b00,6'o00,0,'0);
    vecs[14] = mk(1,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o70, 2'b10,2'b10, P1,  0,1,2'b10,6'o70,0,P1);
    vecs[15] = mk(0,0,1, 6'o00,6'o70, 2'b00,2'b10, 6'o01, 2'b01,2'b00, P2,  0,0,2'b00,6'o00,0,'0);
    vecs[16] = mk(1,0,0, 6'o00,6'o00, 2'b00,2'b00, 6'o01, 2'b01,2'b00, P3,  1,0,2'b00,6'o00,0,'0);
    vecs[17] = mk(1,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o03, 2'b01,2'b01, P4,  0,1,2'b01,6'o03,0,P4);
    vecs[18] = mk(1,0,1, 6'o00,6'o00, 2'b00,2'b00, 6'o30, 2'b10,2'b10, P5,  0,1,2'b10,6'o30,0,P5);
    vecs[19] = mk(1,0,1, 6'o30,6'o00, 2'b10,2'b00, 6'o00, 2'b00,2'b00, P6,  1,0,2'b00,6'o00,0,'0);

    do_reset();
    #1;
    check("reset_ex_valid", valid1, 1'b0);
    check("reset_ex_payload", pl1, '0);

    for (int i = 0; i < 20; i++) begin
      set_in(vecs[i].v, vecs[i].fl, vecs[i].rdy, vecs[i].rsa, vecs[i].rsb, vecs[i].ua,
             vecs[i].ub, vecs[i].rd, vecs[i].we, vecs[i].ld, vecs[i].pl);
      #1;
      check($sformatf("vec%0d_id_stall", i), stall1, vecs[i].e_stall);
      tick();
      check($sformatf("vec%0d_ex_valid", i), valid1, vecs[i].e_valid);
      check($sformatf("vec%0d_ex_rd_we", i), we1, vecs[i].e_we);
      check($sformatf("vec%0d_ex_rd", i), rd1, vecs[i].e_rd);
      check($sformatf("vec%0d_ex_conflict", i), conf1, vecs[i].e_conf);
      check($sformatf("vec%0d_ex_payload", i), pl1, vecs[i].e_pl);
    end

    // LOAD_LAT=3: load r3 in slot1, then slot0 reads r3 -> exactly 3 stall cycles
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    do_reset();
    set_in(1, 0, 1, 6'o00, 6'o00, 2'b00, 2'b00, 6'o30, 2'b10, 2'b10, P1);
    tick();
    check("lat3_load_issue", valid3, 1'b1);
    set_in(1, 0, 1, 6'o03, 6'o00, 2'b01, 2'b00, 6'o01, 2'b01, 2'b00, P2);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!stall3) break;
      n++;
      tick();
      check("lat3_bubble_valid", valid3, 1'b0);
    end
    check("lat3_stall_cycles", n, 3);
    tick();
    check("lat3_reader_valid", valid3, 1'b1);
    check("lat3_reader_payload", pl3, P2);

    // LOAD_LAT=3: reading unrelated r4 while r3 is busy does not stall
    set_in(1, 0, 1, 6'o00, 6'o00, 2'b00, 2'b00, 6'o03, 2'b01, 2'b01, P3);
    tick();
    set_in(1, 0, 1, 6'o04, 6'o00, 2'b01, 2'b00, 6'o00, 2'b00, 2'b00, P4);
    #1;
    check("lat3_r4_no_stall", stall3, 1'b0);
    tick();
    check("lat3_r4_issue", pl3, P4);
    set_in(1, 0, 1, 6'o03, 6'o00, 2'b01, 2'b00, 6'o00, 2'b00, 2'b00, P5);
    #1;
    check("lat3_r3_still_busy", stall3, 1'b1);

    // Back-pressure with r3 pending (LOAD_LAT=1): EX holds, counter frozen
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    do_reset();
    set_in(1, 0, 1, 6'o00, 6'o00, 2'b00, 2'b00, 6'o30, 2'b10, 2'b10, P1);
    tick();
    set_in(1, 0, 0, 6'o03, 6'o00, 2'b01, 2'b00, 6'o01, 2'b01, 2'b00, P2);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("bp_stall", stall1, 1'b1);
      tick();
      check("bp_hold_valid", valid1, 1'b1);
      check("bp_hold_we", we1, 2'b10);
      check("bp_hold_payload", pl1, P1);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_counter_frozen_stall", stall1, 1'b1);
    tick();
    check("bp_bubble", valid1, 1'b0);
    #1;
    check("bp_stall_released", stall1, 1'b0);
    tick();
    check("bp_reader_valid", valid1, 1'b1);
    check("bp_reader_payload", pl1, P2);

    // Asynchronous reset in the middle of a load-use stall
    set_in(1, 0, 1, 6'o00, 6'o00, 2'b00, 2'b00, 6'o33, 2'b11, 2'b10, P3);
    tick();
    check("rst_pre_conflict", conf1, 1'b1);
    set_in(1, 0, 1, 6'o03, 6'o00, 2'b01, 2'b00, 6'o01, 2'b01, 2'b00, P4);
    #1;
    check("rst_pre_stall", stall1, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_async_valid", valid1, 1'b0);
    check("rst_async_we", we1, 2'b00);
    check("rst_async_rd", rd1, 6'o00);
    check("rst_async_payload", pl1, '0);
    check("rst_async_conflict", conf1, 1'b0);
    check("rst_async_no_stall", stall1, 1'b0);
    #1 reset = 1'b1;
    tick();
    check("rst_after_issue_valid", valid1, 1'b1);
    check("rst_after_issue_payload", pl1, P4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
